sign_extend: RTL and testbench

- Immediate-extension unit for the decode stage.
- Widens a 16-bit instruction immediate to the 32-bit datapath width. Supported modes: sign-extend, zero-extend and upper-immediate (LUI) placement.
- Combinational output feeds ALU operand muxing in the same cycle.
- Registered copy with valid flag feeds the next pipeline stage.

---
 rtl/sign_extend_pkg.sv | 14 +
 rtl/sign_extend_if.sv | 18 +
 rtl/sign_extend_core.sv | 43 ++++
 rtl/sign_extend.sv | 49 ++++
 tb/tb_sign_extend.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/sign_extend_pkg.sv
// Shared types and default widths for the decode-stage immediate extender.
package sign_extend_pkg;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_BYTE  = 2'b11
  } ext_mode_e;

  localparam int IMM_WIDTH  = 16;
  localparam int DATA_WIDTH = 32;

endpackage

// File: rtl/sign_extend_if.sv
// Immediate/mode request bundle plus combinational and registered results.
interface sign_extend_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
);
  import sign_extend_pkg::*;

  logic [IN_WIDTH-1:0]  In;
  ext_mode_e            Mode;
  logic                 Enable;
  logic [OUT_WIDTH-1:0] Out;
  logic [OUT_WIDTH-1:0] OutQ;
  logic                 ValidQ;

  modport master (output In, Mode, Enable, input Out, OutQ, ValidQ);
  modport slave  (input In, Mode, Enable, output Out, OutQ, ValidQ);

endinterface

// File: rtl/sign_extend_core.sv
// Combinational In/Mode -> Out extension mux.
// SIGN_EXTEND_BYTE_MODE_EN makes mode 11 sign-extend the low byte; otherwise it aliases mode 00.
module sign_extend_core
  import sign_extend_pkg::*;
#(
  parameter int IN_WIDTH  = IMM_WIDTH,
  parameter int OUT_WIDTH = DATA_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  In,
  input  ext_mode_e            Mode,
  output logic [OUT_WIDTH-1:0] Out
);

  logic signed [OUT_WIDTH-1:0] sext;
  logic        [OUT_WIDTH-1:0] zext;
  logic signed [OUT_WIDTH-1:0] upper;

  assign sext  = OUT_WIDTH'($signed(In));
  assign zext  = OUT_WIDTH'(In);
  // Shifting the sign-extended value leaves any bits above 2*IN_WIDTH sign-filled.
  assign upper = sext <<< IN_WIDTH;

`ifdef SIGN_EXTEND_BYTE_MODE_EN
  logic signed [OUT_WIDTH-1:0] bext;
  assign bext = OUT_WIDTH'($signed(In[7:0]));
`endif

  always_comb begin
    Out = sext;
    case (Mode)
      EXT_SIGN:  Out = sext;
      EXT_ZERO:  Out = zext;
      EXT_UPPER: Out = upper;
`ifdef SIGN_EXTEND_BYTE_MODE_EN
      EXT_BYTE:  Out = bext;
`else
      EXT_BYTE:  Out = sext;
`endif
      default:   Out = sext;
    endcase
  end

endmodule

// File: rtl/sign_extend.sv
// Immediate extension unit: combinational result for ALU muxing plus a registered copy with valid pulse.
// Optional macro SIGN_EXTEND_BYTE_MODE_EN enables low-byte sign extension for mode 11.
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int IN_WIDTH  = IMM_WIDTH,
  parameter int OUT_WIDTH = DATA_WIDTH
) (
  input  logic          Clock,
  input  logic          Reset,
  sign_extend_if.slave  bus
);

  if (IN_WIDTH < 8 || OUT_WIDTH < 2*IN_WIDTH) begin : g_param_err
    $error("sign_extend: need IN_WIDTH >= 8 and OUT_WIDTH >= 2*IN_WIDTH");
  end

  logic [OUT_WIDTH-1:0] ext_p0;
  logic [OUT_WIDTH-1:0] out_p1;
  logic                 vld_p1;

  sign_extend_core #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_core (
    .In   (bus.In),
    .Mode (bus.Mode),
    .Out  (ext_p0)
  );

  assign bus.Out = ext_p0;

  // p0 -> p1: capture on Enable; reset clears both result and valid
  always_ff @(posedge Clock) begin
    if (Reset) begin
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.Enable;
      if (bus.Enable) begin
        out_p1 <= ext_p0;
      end
    end
  end

  assign bus.OutQ   = out_p1;
  assign bus.ValidQ = vld_p1;

endmodule

// File: tb/tb_sign_extend.sv
// Self-checking bench for sign_extend: directed cases, full sign-mode sweep, randomized registered path.
module tb_sign_extend;
  import sign_extend_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [31:0] exp_q;
  logic        exp_v;

  sign_extend_if bus ();

  sign_extend dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference extension computed arithmetically from the mode rules.
  function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic [1:0] m);
    longint unsigned x = 64'(v);
    longint unsigned b = 64'(v) % 256;
    longint unsigned r;
    case (m)
      2'd0: r = (x >= 32768) ? x + 64'hFFFF_0000 : x;
      2'd1: r = x;
      2'd2: r = x * 65536;
`ifdef SIGN_EXTEND_BYTE_MODE_EN
      default: r = (b >= 128) ? b + 64'hFFFF_FF00 : b;
`else
      default: r = (x >= 32768) ? x + 64'hFFFF_0000 : x;
`endif
    endcase
    if (b > 255) r = 0;
    return 32'(r);
  endfunction

  // Advance one edge and update the registered-path scoreboard from current inputs.
  task automatic tick();
    logic [31:0] nq;
    logic        nv;
    nq = exp_q;
    if (rst) begin
      nq = '0;
      nv = 1'b0;
    end else if (bus.Enable) begin
      nq = ref_ext(bus.In, bus.Mode);
      nv = 1'b1;
    end else begin
      nv = 1'b0;
    end
    @(posedge clk);
    #1;
    exp_q = nq;
    exp_v = nv;
  endtask

  task automatic set_in(input logic [15:0] v, input ext_mode_e m, input logic en);
    bus.In     = v;
    bus.Mode   = m;
    bus.Enable = en;
    #1;
  endtask

  initial begin
    logic [15:0] seq [3];
    seq[0] = 16'h0001;
    seq[1] = 16'h8000;
    seq[2] = 16'h7FFF;
    exp_q = '0;
    exp_v = 1'b0;
    rst = 1'b1;
    set_in(16'h0000, EXT_SIGN, 1'b0);

    // Reset for two cycles
    tick();
    tick();
    chk("rst_outq", bus.OutQ, 32'h0);
    chk("rst_validq", 32'(bus.ValidQ), 32'h0);

    // Directed combinational cases
    rst = 1'b0;
    set_in(16'h02E7, EXT_SIGN, 1'b0);  chk("sign_pos", bus.Out, 32'h0000_02E7);
    set_in(16'hF34A, EXT_SIGN, 1'b0);  chk("sign_neg", bus.Out, 32'hFFFF_F34A);
    set_in(16'hF34A, EXT_ZERO, 1'b0);  chk("zero_ext", bus.Out, 32'h0000_F34A);
    set_in(16'hF34A, EXT_UPPER, 1'b0); chk("upper_neg", bus.Out, 32'hF34A_0000);
    set_in(16'h0001, EXT_UPPER, 1'b0); chk("upper_one", bus.Out, 32'h0001_0000);
`ifdef SIGN_EXTEND_BYTE_MODE_EN
    set_in(16'h12A5, EXT_BYTE, 1'b0);  chk("byte_neg", bus.Out, 32'hFFFF_FFA5);
    set_in(16'h807F, EXT_BYTE, 1'b0);  chk("byte_pos", bus.Out, 32'h0000_007F);
`else
    set_in(16'h12A5, EXT_BYTE, 1'b0);  chk("byte_alias", bus.Out, 32'h0000_12A5);
    set_in(16'h807F, EXT_BYTE, 1'b0);  chk("byte_alias_neg", bus.Out, 32'hFFFF_807F);
`endif

    // Capture then hold
    set_in(16'hF34A, EXT_SIGN, 1'b1);
    tick();
    chk("cap_outq", bus.OutQ, 32'hFFFF_F34A);
    chk("cap_validq", 32'(bus.ValidQ), 32'h1);
    set_in(16'h1234, EXT_ZERO, 1'b0);
    tick();
    chk("hold_outq", bus.OutQ, 32'hFFFF_F34A);
    chk("hold_validq", 32'(bus.ValidQ), 32'h0);

    // Reset wins over Enable; Out keeps tracking during reset
    rst = 1'b1;
    set_in(16'h1234, EXT_SIGN, 1'b1);
    chk("rst_comb_out", bus.Out, 32'h0000_1234);
    tick();
    chk("rst_en_outq", bus.OutQ, 32'h0);
    chk("rst_en_validq", 32'(bus.ValidQ), 32'h0);
    set_in(16'hABCD, EXT_SIGN, 1'b1);
    chk("rst_comb_out2", bus.Out, 32'hFFFF_ABCD);
    rst = 1'b0;

    // Back-to-back captures
    for (int i = 0; i < 3; i++) begin
      set_in(seq[i], EXT_SIGN, 1'b1);
      tick();
      chk("b2b_outq", bus.OutQ, ref_ext(seq[i], 2'd0));
      chk("b2b_validq", 32'(bus.ValidQ), 32'h1);
    end
    chk("b2b_last", bus.OutQ, 32'h0000_7FFF);

    // Exhaustive sign-mode sweep
    bus.Enable = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] v;
      v = 16'(i);
      set_in(v, EXT_SIGN, 1'b0);
      chk("sweep_sign", bus.Out, {{16{v[15]}}, v});
    end
    tick();

    // Randomized mixed traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      logic [15:0] v;
      logic [1:0]  m;
      v   = 16'($urandom);
      m   = 2'($urandom);
      rst = ($urandom_range(0, 15) == 0);
      set_in(v, ext_mode_e'(m), 1'($urandom));
      chk("rnd_out", bus.Out, ref_ext(v, m));
      tick();
      chk("rnd_outq", bus.OutQ, exp_q);
      chk("rnd_validq", 32'(bus.ValidQ), 32'(exp_v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
